output_driver: RTL and testbench
================================

Name: output_driver

Overview:
- Event-receiver output generator; turns a one-cycle event trigger into a SERDES-width parallel word stream (serdesPattern) for an output serializer.
- Modes: disabled, single delayed pulse, one-shot pattern, looping pattern.
- Configured through one 32-bit CSR word (opcode + payload).
- Single clock domain; CSR strobe/data arrive already synchronous to evrClk (upstream CDC).

Parameters:
SERDES_WIDTH, 4, bits per output word
COARSE_DELAY_WIDTH, 22, delay counter width (evrClk cycles)
COARSE_WIDTH_WIDTH, 22, pulse width counter width (evrClk cycles)
PATTERN_ADDRESS_WIDTH, 12, pattern RAM address width
DEBUG, "false", "true" adds mark_debug attributes only; no functional effect

Ports:
evrClk  in  1  sole clock
evrReset  in  1  synchronous, active-high reset
csrStrobe  in  1  write strobe for CSR word
GPIO_OUT  in  32  CSR write data
triggerStrobe  in  1  one-cycle event trigger
serdesPattern  out  SERDES_WIDTH  registered output word, LSB first in time

Behaviour:
- One clock (evrClk); reset synchronous, active-high.
- CSR decode on csrStrobe=1, opcode GPIO_OUT[31:30]:
  - 00 SET_MODE: mode=[1:0] (0 DISABLED, 1 PULSE, 2 PATTERN_SINGLE, 3 PATTERN_LOOP).
  - 01 SET_DELAY: coarseDelay=[SERDES_WIDTH +: COARSE_DELAY_WIDTH]; firstPattern=[SERDES_WIDTH-1:0].
  - 10 SET_WIDTH: coarseWidth=[SERDES_WIDTH +: COARSE_WIDTH_WIDTH]; lastPattern=[SERDES_WIDTH-1:0].
  - 11 SET_PATTERN: RAM[addr=[10 +: PATTERN_ADDRESS_WIDTH]] <= [SERDES_WIDTH-1:0]; patternEnd <= addr.
  - Pattern length is patternEnd+1. Software writes addresses ascending; the last write defines the length.
- Reset values:
  - serdesPattern=0, mode=DISABLED.
  - coarseDelay, coarseWidth, firstPattern, lastPattern, patternEnd all 0.
  - Sequencer IDLE.
  - Pattern RAM contents are not cleared.
- Sequencer states: IDLE, DELAY, PLAY.
  - IDLE -> DELAY on triggerStrobe when mode!=DISABLED.
  - DELAY counts coarseDelay cycles, then -> PLAY.
  - Latency: with D=coarseDelay, the first word appears on serdesPattern D+2 cycles after the edge that samples triggerStrobe (one state cycle plus one output/RAM register cycle).
- PULSE, W=coarseWidth:
  - W>=1: firstPattern, then all-ones for W-1 words, then lastPattern (W+1 words total).
  - W=0: single word firstPattern & lastPattern.
  - Then zeros; -> IDLE.
- PATTERN_SINGLE: RAM[0..patternEnd] once, then zeros; -> IDLE.
- PATTERN_LOOP: RAM[0..patternEnd] repeated with wrap to 0 and no gap; stays in PLAY until mode changes.
- Output is 0 whenever not in PLAY.
- Retrigger: a trigger in DELAY or PLAY restarts from the DELAY state (address 0 / pulse start). This includes resync in loop mode.
- Any SET_MODE write aborts activity: -> IDLE, output 0 next cycle. A trigger on the same edge as SET_MODE is ignored.
- Delay, width, first/last and patternEnd are captured at trigger. CSR writes during a sequence affect only the next trigger.
- Pattern RAM: read-during-write returns old data.
- Counters use full parameter width with no overflow; max delay is 2^COARSE_DELAY_WIDTH-1.
- evrReset mid-sequence: output 0 on the next cycle; all registers return to reset values.

Decomposition:
- Shared package output_driver_pkg: opcode constants (00/01/10/11 at [31:30]), mode encodings, PATTERN_ADDRESS_SHIFT=10.
- Sub-module output_driver_pattern_ram: 2^PATTERN_ADDRESS_WIDTH x SERDES_WIDTH simple dual-port RAM with synchronous read.

Test Plan:
- Reset, then trigger in any mode -> serdesPattern stays 4'h0; mode reads DISABLED.
- PULSE, D=0, W=10, first=last=F, trigger at edge k -> 4'hF for exactly 11 cycles starting at k+2, then 0.
- PULSE, D=5, W=0, first=C, last=6 -> single word 4'h4 at k+7.
- Pattern words F,1,0,0 at addresses 0..3; PATTERN_SINGLE, D=0 -> F,1,0,0 once from k+2, then 0; a second trigger replays it.
- Same pattern, PATTERN_LOOP -> F,1,0,0 repeating with no gap; trigger mid-loop restarts at F after 2 cycles.
- Mode change LOOP->PULSE mid-play -> output 0 next cycle; next trigger yields a pulse. SET_MODE coincident with trigger -> trigger ignored.

Source files
------------

// File: rtl/output_driver_pkg.sv
// Shared constants and types for the event-receiver output driver.
package output_driver_pkg;

    // Bit position of the pattern RAM address inside a SET_PATTERN word.
    localparam int unsigned PATTERN_ADDRESS_SHIFT = 10;

    // CSR opcode, carried in GPIO_OUT[31:30].
    typedef enum logic [1:0] {
        OpSetMode    = 2'b00,
        OpSetDelay   = 2'b01,
        OpSetWidth   = 2'b10,
        OpSetPattern = 2'b11
    } csr_op_e;

    // Output mode, carried in GPIO_OUT[1:0] of a SET_MODE word.
    typedef enum logic [1:0] {
        ModeDisabled      = 2'b00,
        ModePulse         = 2'b01,
        ModePatternSingle = 2'b10,
        ModePatternLoop   = 2'b11
    } mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StDelay = 2'b01,
        StPlay  = 2'b10
    } seq_state_e;

endpackage

// File: rtl/output_driver_pattern_ram.sv
// Simple dual-port pattern RAM, synchronous read, read-during-write returns old data.
module output_driver_pattern_ram #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port and registered read port; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/output_driver.sv
// Event-receiver output generator: turns a trigger into a delayed pulse or a
// pattern stream of SERDES-width words for an output serializer.
module output_driver
    import output_driver_pkg::*;
#(
    parameter int unsigned SERDES_WIDTH          = 4,
    parameter int unsigned COARSE_DELAY_WIDTH    = 22,
    parameter int unsigned COARSE_WIDTH_WIDTH    = 22,
    parameter int unsigned PATTERN_ADDRESS_WIDTH = 12,
    parameter string       DEBUG                 = "false"
) (
    input  logic                    evrClk,
    input  logic                    evrReset,
    input  logic                    csrStrobe,
    input  logic [31:0]             GPIO_OUT,
    input  logic                    triggerStrobe,
    output logic [SERDES_WIDTH-1:0] serdesPattern
);

    // Word index must reach both the pulse width and the last pattern address.
    localparam int unsigned IDX_WIDTH = (COARSE_WIDTH_WIDTH > PATTERN_ADDRESS_WIDTH) ?
                                        COARSE_WIDTH_WIDTH : PATTERN_ADDRESS_WIDTH;

    csr_op_e                        csr_op;
    logic                           wr_mode, wr_delay, wr_width, wr_pattern;
    logic [PATTERN_ADDRESS_WIDTH-1:0] pat_addr;

    // CSR-visible configuration.
    mode_e                          mode_q;
    logic [COARSE_DELAY_WIDTH-1:0]  delay_q;
    logic [COARSE_WIDTH_WIDTH-1:0]  width_q;
    logic [SERDES_WIDTH-1:0]        first_q, last_q;
    logic [PATTERN_ADDRESS_WIDTH-1:0] pattern_end_q;

    // Sequencer state and values captured at trigger.
    seq_state_e                     state_q, state_d;
    logic [COARSE_DELAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic [IDX_WIDTH-1:0]           end_idx_q, end_idx_d;
    logic [SERDES_WIDTH-1:0]        cap_first_q, cap_first_d;
    logic [SERDES_WIDTH-1:0]        cap_last_q, cap_last_d;
    logic                           cap_wzero_q, cap_wzero_d;

    logic [SERDES_WIDTH-1:0]        ram_rdata;
    logic [SERDES_WIDTH-1:0]        pulse_word;
    logic [SERDES_WIDTH-1:0]        out_q, out_d;

    logic                           unused_gpio;

    assign csr_op      = csr_op_e'(GPIO_OUT[31:30]);
    assign wr_mode     = csrStrobe && (csr_op == OpSetMode);
    assign wr_delay    = csrStrobe && (csr_op == OpSetDelay);
    assign wr_width    = csrStrobe && (csr_op == OpSetWidth);
    assign wr_pattern  = csrStrobe && (csr_op == OpSetPattern);
    assign pat_addr    = GPIO_OUT[PATTERN_ADDRESS_SHIFT +: PATTERN_ADDRESS_WIDTH];
    assign unused_gpio = ^GPIO_OUT;

    // CSR register file.
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            mode_q        <= ModeDisabled;
            delay_q       <= '0;
            width_q       <= '0;
            first_q       <= '0;
            last_q        <= '0;
            pattern_end_q <= '0;
        end else begin
            if (wr_mode) begin
                mode_q <= mode_e'(GPIO_OUT[1:0]);
            end
            if (wr_delay) begin
                delay_q <= GPIO_OUT[SERDES_WIDTH +: COARSE_DELAY_WIDTH];
                first_q <= GPIO_OUT[SERDES_WIDTH-1:0];
            end
            if (wr_width) begin
                width_q <= GPIO_OUT[SERDES_WIDTH +: COARSE_WIDTH_WIDTH];
                last_q  <= GPIO_OUT[SERDES_WIDTH-1:0];
            end
            if (wr_pattern) begin
                pattern_end_q <= pat_addr;
            end
        end
    end

    // Pattern RAM; the read address is the next word index so data is ready in PLAY.
    output_driver_pattern_ram #(
        .DATA_WIDTH (SERDES_WIDTH),
        .ADDR_WIDTH (PATTERN_ADDRESS_WIDTH)
    ) u_pattern_ram (
        .clk_i   (evrClk),
        .we_i    (wr_pattern && !evrReset),
        .waddr_i (pat_addr),
        .wdata_i (GPIO_OUT[SERDES_WIDTH-1:0]),
        .raddr_i (idx_d[PATTERN_ADDRESS_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // Sequencer state register.
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            end_idx_q   <= '0;
            cap_first_q <= '0;
            cap_last_q  <= '0;
            cap_wzero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            end_idx_q   <= end_idx_d;
            cap_first_q <= cap_first_d;
            cap_last_q  <= cap_last_d;
            cap_wzero_q <= cap_wzero_d;
        end
    end

    // Sequencer next state: mode write aborts, trigger (re)starts, else advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        end_idx_d   = end_idx_q;
        cap_first_d = cap_first_q;
        cap_last_d  = cap_last_q;
        cap_wzero_d = cap_wzero_q;
        if (wr_mode) begin
            state_d = StIdle;
            idx_d   = '0;
        end else if (triggerStrobe && (mode_q != ModeDisabled)) begin
            state_d     = StDelay;
            cnt_d       = delay_q;
            idx_d       = '0;
            end_idx_d   = (mode_q == ModePulse) ? IDX_WIDTH'(width_q)
                                                : IDX_WIDTH'(pattern_end_q);
            cap_first_d = first_q;
            cap_last_d  = last_q;
            cap_wzero_d = (width_q == '0);
        end else begin
            case (state_q)
                StDelay: begin
                    idx_d = '0;
                    if (cnt_q == '0) begin
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StPlay: begin
                    if (idx_q == end_idx_q) begin
                        idx_d = '0;
                        if (mode_q != ModePatternLoop) begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StIdle:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Pulse word for the current index: first, all-ones body, last.
    always_comb begin
        pulse_word = '1;
        if (cap_wzero_q) begin
            pulse_word = cap_first_q & cap_last_q;
        end else if (idx_q == '0) begin
            pulse_word = cap_first_q;
        end else if (idx_q == end_idx_q) begin
            pulse_word = cap_last_q;
        end
    end

    // Output word select; zero outside PLAY and on the cycle of a mode write.
    always_comb begin
        out_d = '0;
        if ((state_q == StPlay) && !wr_mode) begin
            out_d = (mode_q == ModePulse) ? pulse_word : ram_rdata;
        end
    end

    // Output register.
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign serdesPattern = out_q;

    if (DEBUG == "true") begin : g_debug
        (* mark_debug = "true" *) logic [1:0]              debug_state;
        (* mark_debug = "true" *) logic [SERDES_WIDTH-1:0] debug_out;
        assign debug_state = state_q;
        assign debug_out   = out_q;
    end

endmodule

// File: tb/tb_output_driver.sv
// Scoreboard bench for output_driver: expected words are queued per cycle when
// stimulus is driven and compared against serdesPattern on the falling edge.
module tb_output_driver;

    logic        evrClk = 1'b0;
    logic        evrReset;
    logic        csrStrobe;
    logic [31:0] GPIO_OUT;
    logic        triggerStrobe;
    logic [3:0]  serdesPattern;

    typedef struct {
        int         c;
        logic [3:0] v;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] pat[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    output_driver #(
        .SERDES_WIDTH          (4),
        .COARSE_DELAY_WIDTH    (22),
        .COARSE_WIDTH_WIDTH    (22),
        .PATTERN_ADDRESS_WIDTH (12),
        .DEBUG                 ("false")
    ) dut (
        .evrClk        (evrClk),
        .evrReset      (evrReset),
        .csrStrobe     (csrStrobe),
        .GPIO_OUT      (GPIO_OUT),
        .triggerStrobe (triggerStrobe),
        .serdesPattern (serdesPattern)
    );

    always #5 evrClk = ~evrClk;

    always @(posedge evrClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the word produced by the edge numbered cyc.
    always @(negedge evrClk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            check("stale_entry", e.c, cyc);
        end else if (sb.size() > 0 && sb[0].c == cyc) begin
            e = sb.pop_front();
            check($sformatf("out@%0d", cyc), {28'h0, serdesPattern}, {28'h0, e.v});
        end
    end

    function automatic void push(input int c, input logic [3:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        sb.push_back(e);
    endfunction

    function automatic void cut(input int c);
        while (sb.size() > 0 && sb[$].c >= c) void'(sb.pop_back());
    endfunction

    function automatic void zeros(input int from, input int n);
        for (int i = 0; i < n; i++) push(from + i, 4'h0);
    endfunction

    function automatic logic [31:0] w_mode(input logic [1:0] m);
        logic [31:0] x = '0;
        x[1:0] = m;
        return x;
    endfunction

    function automatic logic [31:0] w_dw(input logic [1:0] op, input int val, input logic [3:0] p);
        logic [31:0] x = '0;
        x[31:30] = op;
        x[25:4]  = 22'(val);
        x[3:0]   = p;
        return x;
    endfunction

    function automatic logic [31:0] w_pat(input int addr, input logic [3:0] p);
        logic [31:0] x = '0;
        x[31:30] = 2'b11;
        x[21:10] = 12'(addr);
        x[3:0]   = p;
        return x;
    endfunction

    // CSR write; a SET_MODE write forces zeros from the sampling edge on.
    task automatic csr(input logic [31:0] data);
        int m;
        @(negedge evrClk);
        csrStrobe = 1'b1;
        GPIO_OUT  = data;
        m = cyc + 1;
        if (data[31:30] == 2'b00) begin
            cut(m);
            zeros(m, 3);
        end
        @(negedge evrClk);
        csrStrobe = 1'b0;
    endtask

    // Trigger sampled at edge k: DELAY zeros, words of pat from k+d+2, then tail zeros.
    task automatic trigger(input int d, input int tail);
        int k;
        @(negedge evrClk);
        triggerStrobe = 1'b1;
        k = cyc + 1;
        cut(k + 1);
        zeros(k + 1, d + 1);
        foreach (pat[i]) push(k + d + 2 + i, pat[i]);
        zeros(k + d + 2 + pat.size(), tail);
        @(negedge evrClk);
        triggerStrobe = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge evrClk);
        check("drain", sb.size(), 0);
    endtask

    task automatic fill(input logic [3:0] v, input int n);
        pat.delete();
        for (int i = 0; i < n; i++) pat.push_back(v);
    endtask

    task automatic fill_loop(input int periods);
        pat.delete();
        for (int i = 0; i < periods; i++) begin
            pat.push_back(4'hF);
            pat.push_back(4'h1);
            pat.push_back(4'h0);
            pat.push_back(4'h0);
        end
    endtask

    initial begin
        int r;
        evrReset      = 1'b1;
        csrStrobe     = 1'b0;
        GPIO_OUT      = '0;
        triggerStrobe = 1'b0;
        zeros(1, 5);
        repeat (5) @(negedge evrClk);
        evrReset = 1'b0;

        // Disabled after reset: trigger has no effect.
        pat.delete();
        trigger(0, 8);
        drain();

        // PULSE D=0 W=10 first=last=F: eleven F words.
        csr(w_mode(2'd1));
        csr(w_dw(2'b01, 0, 4'hF));
        csr(w_dw(2'b10, 10, 4'hF));
        fill(4'hF, 11);
        trigger(0, 3);
        drain();

        // PULSE D=5 W=0 first=C last=6: single word C&6=4.
        csr(w_dw(2'b01, 5, 4'hC));
        csr(w_dw(2'b10, 0, 4'h6));
        pat.delete();
        pat.push_back(4'h4);
        trigger(5, 3);
        drain();

        // Delay write during a sequence only affects the next trigger.
        csr(w_dw(2'b01, 3, 4'h1));
        csr(w_dw(2'b10, 2, 4'h8));
        pat.delete();
        pat.push_back(4'h1);
        pat.push_back(4'hF);
        pat.push_back(4'h8);
        trigger(3, 0);
        csr(w_dw(2'b01, 1, 4'h2));
        drain();
        zeros(cyc + 1, 3);
        pat[0] = 4'h2;
        trigger(1, 3);
        drain();

        // PATTERN_SINGLE with F,1,0,0, played twice.
        csr(w_pat(0, 4'hF));
        csr(w_pat(1, 4'h1));
        csr(w_pat(2, 4'h0));
        csr(w_pat(3, 4'h0));
        csr(w_mode(2'd2));
        csr(w_dw(2'b01, 0, 4'h0));
        fill_loop(1);
        trigger(0, 3);
        drain();
        trigger(0, 3);
        drain();

        // PATTERN_LOOP, mid-loop resync, then abort by switching to PULSE.
        csr(w_mode(2'd3));
        fill_loop(6);
        trigger(0, 0);
        repeat (9) @(negedge evrClk);
        trigger(0, 0);
        repeat (7) @(negedge evrClk);
        csr(w_mode(2'd1));
        drain();
        csr(w_dw(2'b10, 1, 4'hC));
        csr(w_dw(2'b01, 0, 4'h3));
        pat.delete();
        pat.push_back(4'h3);
        pat.push_back(4'hC);
        trigger(0, 3);
        drain();

        // SET_MODE on the same edge as a trigger: trigger ignored.
        @(negedge evrClk);
        csrStrobe     = 1'b1;
        GPIO_OUT      = w_mode(2'd3);
        triggerStrobe = 1'b1;
        cut(cyc + 1);
        zeros(cyc + 1, 8);
        @(negedge evrClk);
        csrStrobe     = 1'b0;
        triggerStrobe = 1'b0;
        drain();

        // Reset in the middle of a loop: output zero and mode back to DISABLED.
        fill_loop(6);
        trigger(0, 0);
        repeat (5) @(negedge evrClk);
        evrReset = 1'b1;
        r = cyc + 1;
        cut(r);
        zeros(r, 4);
        repeat (2) @(negedge evrClk);
        evrReset = 1'b0;
        drain();
        pat.delete();
        trigger(0, 8);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
